// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipelined_adder_pkg : shared mode encodings and counter width        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipelined_adder_pkg;

  typedef enum logic [1:0] {
    MODE_ADD     = 2'b00,
    MODE_SUB     = 2'b01,
    MODE_SAT_ADD = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam int c_op_count_w = 16;

endpackage : pipelined_adder_pkg
`default_nettype wire

// File: rtl/pipelined_adder_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_slice : combinational SLICE_W-bit add with carry in / out      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adder_slice
  import pipelined_adder_pkg::*;
#(
  parameter int SLICE_W = 2
) (
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout
);

  logic [SLICE_W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SLICE_W{1'b0}}, i_cin};
  assign o_sum  = w_full[SLICE_W-1:0];
  assign o_cout = w_full[SLICE_W];

endmodule : adder_slice
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipelined_adder : STAGES-deep sliced adder (ADD/SUB/SAT_ADD), stall  |
// | by global enable, saturating handshake counter.  Rev 1.0             |
// +----------------------------------------------------------------------+
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic [1:0]              mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH:0]          sum,
  output logic                    out_flag,
  input  logic                    clear_count,
  output logic [c_op_count_w-1:0] op_count
);

  localparam int c_slice_w = WIDTH / STAGES;
  localparam int c_last    = STAGES - 1;

  if (WIDTH < 2 || WIDTH > 32 || STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0) begin : g_bad_param
    $error("pipelined_adder: illegal WIDTH/STAGES combination");
  end

  // Each beat carries a rotating operand window: the low slice is consumed
  // per stage and the produced sum slice enters at the top, so after STAGES
  // rotations r_xa holds the complete sum in natural order.
  logic             r_v    [STAGES];
  logic [WIDTH-1:0] r_xa   [STAGES];
  logic [WIDTH-1:0] r_xb   [STAGES];
  logic             r_c    [STAGES];
  mode_e            r_mode [STAGES];

  logic             w_v_in    [STAGES];
  logic [WIDTH-1:0] w_xa_in   [STAGES];
  logic [WIDTH-1:0] w_xb_in   [STAGES];
  logic             w_c_in    [STAGES];
  mode_e            w_mode_in [STAGES];
  logic [WIDTH-1:0] w_xa_nx   [STAGES];
  logic [WIDTH-1:0] w_xb_nx   [STAGES];
  logic             w_c_nx    [STAGES];

  logic             w_en;
  logic [c_op_count_w-1:0] r_op_count;

  assign w_en      = !r_v[c_last] || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v[c_last];
  assign op_count  = r_op_count;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [c_slice_w-1:0] w_slice;

    if (k == 0) begin : g_head
      // Subtraction is a + ~b + 1: invert B and seed carry-in once at entry.
      assign w_v_in[k]    = in_valid;
      assign w_xa_in[k]   = a;
      assign w_xb_in[k]   = (mode == MODE_SUB) ? ~b : b;
      assign w_c_in[k]    = (mode == MODE_SUB);
      assign w_mode_in[k] = mode_e'(mode);
    end else begin : g_body
      assign w_v_in[k]    = r_v[k-1];
      assign w_xa_in[k]   = r_xa[k-1];
      assign w_xb_in[k]   = r_xb[k-1];
      assign w_c_in[k]    = r_c[k-1];
      assign w_mode_in[k] = r_mode[k-1];
    end

    adder_slice #(
      .SLICE_W (c_slice_w)
    ) u_slice (
      .i_a    (w_xa_in[k][c_slice_w-1:0]),
      .i_b    (w_xb_in[k][c_slice_w-1:0]),
      .i_cin  (w_c_in[k]),
      .o_sum  (w_slice),
      .o_cout (w_c_nx[k])
    );

    if (STAGES == 1) begin : g_norot
      assign w_xa_nx[k] = w_slice;
      assign w_xb_nx[k] = w_xb_in[k];
    end else begin : g_rot
      assign w_xa_nx[k] = {w_slice, w_xa_in[k][WIDTH-1:c_slice_w]};
      assign w_xb_nx[k] = {w_xb_in[k][c_slice_w-1:0], w_xb_in[k][WIDTH-1:c_slice_w]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k]    <= 1'b0;
        r_xa[k]   <= '0;
        r_xb[k]   <= '0;
        r_c[k]    <= 1'b0;
        r_mode[k] <= MODE_ADD;
      end
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k]    <= w_v_in[k];
        r_xa[k]   <= w_xa_nx[k];
        r_xb[k]   <= w_xb_nx[k];
        r_c[k]    <= w_c_nx[k];
        r_mode[k] <= w_mode_in[k];
      end
    end
  end

  // The B window has no use once the last slice is added.
  logic w_unused_xb;
  assign w_unused_xb = ^r_xb[c_last];

  always_comb begin
    sum      = {r_c[c_last], r_xa[c_last]};
    out_flag = r_c[c_last];
    case (r_mode[c_last])
      MODE_SUB: begin
        sum      = {~r_c[c_last], r_xa[c_last]};
        out_flag = ~r_c[c_last];
      end
      MODE_SAT_ADD: begin
        if (r_c[c_last]) begin
          sum      = {1'b0, {WIDTH{1'b1}}};
          out_flag = 1'b1;
        end else begin
          sum      = {1'b0, r_xa[c_last]};
          out_flag = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (clear_count) begin
      r_op_count <= '0;
    end else if (out_valid && out_ready && (r_op_count != {c_op_count_w{1'b1}})) begin
      r_op_count <= r_op_count + {{(c_op_count_w-1){1'b0}}, 1'b1};
    end
  end

endmodule : pipelined_adder
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipelined_adder : scoreboard bench with arithmetic reference model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipelined_adder;
  import pipelined_adder_pkg::*;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   mode = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W:0]   sum;
  logic         out_flag;
  logic         clear_count = 1'b0;
  logic [15:0]  op_count;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .mode        (mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .out_flag    (out_flag),
    .clear_count (clear_count),
    .op_count    (op_count)
  );

  typedef struct {
    logic [W:0] s;
    logic       f;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic       lat_chk = 1'b0;
  int         exp_cnt = 0;
  logic       held_v = 1'b0;
  logic [W:0] held_s;
  logic       held_f;

  function automatic exp_t model(input int unsigned aa, input int unsigned bb, input int m, input int acc);
    exp_t        e;
    int unsigned t;
    int unsigned lim;
    lim   = 1 << W;
    e.acc = acc;
    case (m)
      1: begin
        e.f = (aa < bb);
        t   = (aa + lim - bb) % lim;
        e.s = (W+1)'(e.f ? lim + t : t);
      end
      2: begin
        t = aa + bb;
        e.f = (t >= lim);
        e.s = (W+1)'(e.f ? lim - 1 : t);
      end
      default: begin
        t = aa + bb;
        e.s = (W+1)'(t);
        e.f = (t >= lim);
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned req);
    n_vec++;
    if (act != req) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor / scoreboard: everything is sampled mid-cycle, describing the
  // handshakes that the next rising edge will commit.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 0;
      held_v  = 1'b0;
    end else begin
      chk("op_count", op_count, exp_cnt);
      chk("in_ready_eq_en", in_ready, (!out_valid || out_ready));
      if (held_v) begin
        chk("held_valid", out_valid, 1);
        chk("held_sum", sum, held_s);
        chk("held_flag", out_flag, held_f);
      end
      held_v = out_valid && !out_ready;
      held_s = sum;
      held_f = out_flag;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sum", sum, e.s);
          chk("flag", out_flag, e.f);
          if (lat_chk) chk("latency", cyc - e.acc, S);
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(a, b, mode, cyc));
      if (clear_count)
        exp_cnt = 0;
      else if (out_valid && out_ready && exp_cnt < 65535)
        exp_cnt = exp_cnt + 1;
    end
    cyc++;
  end

  task automatic send(input int aa, input int bb, input int m);
    int k;
    in_valid = 1'b1;
    a        = W'(aa);
    b        = W'(bb);
    mode     = 2'(m);
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("drain_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_flag", out_flag, 0);
    chk("reset_op_count", op_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);

    // Directed arithmetic with latency checking
    lat_chk = 1'b1;
    send(2, 3, 0);
    send(8, 6, 0);
    send(15, 15, 0);
    send(4, 5, 1);
    send(5, 4, 1);
    send(15, 1, 2);
    send(7, 8, 2);
    send(9, 9, 3);
    send(0, 15, 1);
    drain();
    lat_chk = 1'b0;

    // Five-beat stream with a three-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 5; i++)
          send($urandom_range(15), $urandom_range(15), $urandom_range(3));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic and back-pressure
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(9) < 7);
      a         = W'($urandom);
      b         = W'($urandom);
      mode      = 2'($urandom);
      out_ready = ($urandom_range(9) < 7);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with two beats in flight
    send(3, 4, 0);
    send(1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_op_count", op_count, 0);
    chk("async_rst_sum", sum, 0);
    chk("async_rst_flag", out_flag, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      chk("stale_out_valid", out_valid, 0);
      @(negedge clk);
    end

    // Saturate op_count, then clear during a live handshake
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 65600; i++) begin
      @(posedge clk);
      #1;
      a    = W'($urandom);
      b    = W'($urandom);
      mode = 2'($urandom);
    end
    in_valid = 1'b0;
    drain();
    chk("op_count_saturated", op_count, 16'hFFFF);
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    clear_count = 1'b1;
    @(negedge clk);
    chk("clear_concurrent_hs", (out_valid && out_ready), 1);
    @(posedge clk);
    #1;
    clear_count = 1'b0;
    in_valid    = 1'b0;
    @(negedge clk);
    chk("op_count_cleared", op_count, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pipelined_adder
`default_nettype wire

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal values 2..32.
REQ-002 Parameter STAGES, default 2, number of pipeline stages; legal values 1..4; WIDTH % STAGES SHALL be 0 (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned.
REQ-008 b  input  WIDTH  operand B, unsigned.
REQ-009 mode  input  2  operation: 00 ADD, 01 SUB, 10 SAT_ADD, 11 reserved (executes as ADD).
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 sum  output  WIDTH+1  result.
REQ-013 out_flag  output  1  carry / borrow / saturated indicator.
REQ-014 clear_count  input  1  synchronous clear of op_count.
REQ-015 op_count  output  16  count of completed output handshakes.

Function
REQ-016 Input handshake at in_valid && in_ready; output handshake at out_valid && out_ready.
REQ-017 Global advance enable en = !out_valid || out_ready; in_ready SHALL equal en; when en=0 every stage holds its contents.
REQ-018 Latency SHALL be exactly STAGES cycles from input handshake to out_valid when out_ready stays 1; throughput one beat per cycle.
REQ-019 Bubbles SHALL propagate as invalid stages (no collapsing); result order SHALL equal acceptance order; no beat dropped or duplicated under any stall pattern.
REQ-020 Stage k adds bit slice k of width WIDTH/STAGES, LSB slice first, with carry registered into stage k+1; unprocessed upper slices and mode travel with the beat.
REQ-021 ADD: sum = a + b (full WIDTH+1 bits); out_flag = sum[WIDTH].
REQ-022 SUB: computed as a + ~b + 1; sum[WIDTH-1:0] = two's-complement difference; sum[WIDTH] = out_flag = borrow = 1 iff a < b.
REQ-023 SAT_ADD: if a + b >= 2^WIDTH then sum = {0, all ones} and out_flag = 1, else sum = {0, a+b} and out_flag = 0.
REQ-024 sum and out_flag SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 op_count increments by 1 per output handshake, saturates at 0xFFFF (no wrap).
REQ-026 clear_count=1 sets op_count to 0 next edge; clear and simultaneous handshake -> 0 (clear wins).

Reset
REQ-027 rst_n=0 SHALL immediately clear all stage valid bits, out_valid=0, op_count=0, sum=0, out_flag=0.
REQ-028 Reset mid-operation discards all in-flight beats; first edge after deassertion has in_ready=1.
REQ-029 Datapath registers other than sum/out_flag need not be reset.

Structure
REQ-030 Package pipelined_adder_pkg SHALL hold the mode encodings (ADD, SUB, SAT_ADD, RSVD) and the op_count width constant (16).
REQ-031 One sub-module adder_slice: WIDTH/STAGES-bit add with carry-in/carry-out, combinational, instantiated once per stage.
REQ-032 Stage valid/payload registers and the handshake live in pipelined_adder; no other hierarchy.

Verification (WIDTH=4, STAGES=2, out_ready=1 unless stated)
REQ-033 ADD a=2,b=3 then a=8,b=6 on consecutive cycles -> sum=5 then 14, flag 0, out_valid exactly 2 cycles after each accept; ADD 15+15 -> sum=5'b11110, flag 1.
REQ-034 SUB a=4,b=5 -> sum=5'b11111, flag 1; SUB a=5,b=4 -> sum=1, flag 0.
REQ-035 SAT_ADD a=15,b=1 -> sum=15, flag 1; SAT_ADD a=7,b=8 -> sum=15, flag 0.
REQ-036 Stream 5 beats, out_ready=0 for 3 cycles mid-stream -> in_ready falls same cycle, sum held stable, all 5 results delivered in order.
REQ-037 Assert rst_n=0 with 2 beats in flight -> out_valid=0 asynchronously, no stale result after release, op_count=0.
REQ-038 Force 65537 handshakes -> op_count=0xFFFF; clear_count with concurrent handshake -> op_count=0.
